// File: rtl/forwarding_scoreboard.sv
// Forwarding and load-use hazard unit: a shifting scoreboard of in-flight destinations after EX,
// per-source forward-select generation, and a saturating stall counter.
module forwarding_scoreboard #(
  parameter int unsigned RegAddrW  = 5,
  parameter int unsigned NumSrc    = 2,
  parameter int unsigned Depth     = 2,
  parameter int unsigned LoadStage = 2,
  parameter int unsigned CntW      = 32,
  localparam int unsigned SelW     = $clog2(Depth + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ex_valid_i,
  input  logic [RegAddrW-1:0]        ex_rd_i,
  input  logic                       ex_regwrite_i,
  input  logic                       ex_is_load_i,
  input  logic [NumSrc*RegAddrW-1:0] ex_rs_i,
  input  logic [NumSrc-1:0]          ex_rs_used_i,
  input  logic                       hold_i,
  input  logic                       flush_ex_i,
  output logic [NumSrc*SelW-1:0]     sel_o,
  output logic                       stall_o,
  output logic [CntW-1:0]            stall_cnt_o
);

  // Index 0 is stage 1 (EX/MEM), the youngest producer.
  logic [Depth-1:0]    vld_q, vld_d;
  logic [RegAddrW-1:0] rd_q    [Depth];
  logic [RegAddrW-1:0] rd_d    [Depth];
  logic [SelW-1:0]     avail_q [Depth];
  logic [SelW-1:0]     avail_d [Depth];
  logic [CntW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [NumSrc-1:0]   not_ready;

  always_comb begin
    sel_o     = '0;
    not_ready = '0;
    for (int i = 0; i < NumSrc; i++) begin
      logic [RegAddrW-1:0] rs;
      logic                chk;
      logic [SelW-1:0]     sel_v;
      logic [SelW-1:0]     av;
      rs    = ex_rs_i[i*RegAddrW +: RegAddrW];
      chk   = ex_valid_i && ex_rs_used_i[i] && (rs != '0);
      sel_v = '0;
      av    = '0;
      // Scan oldest to youngest so the youngest match is the last one written.
      for (int k = Depth - 1; k >= 0; k--) begin
        if (chk && vld_q[k] && (rd_q[k] == rs)) begin
          sel_v = SelW'(k + 1);
          av    = avail_q[k];
        end
      end
      sel_o[i*SelW +: SelW] = sel_v;
      not_ready[i]          = (av > sel_v);
    end
    stall_o = (|not_ready) && ex_valid_i && !flush_ex_i;
  end

  always_comb begin
    vld_d       = vld_q;
    rd_d        = rd_q;
    avail_d     = avail_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold_i) begin
      for (int k = Depth - 1; k > 0; k--) begin
        vld_d[k]   = vld_q[k-1];
        rd_d[k]    = rd_q[k-1];
        avail_d[k] = avail_q[k-1];
      end
      vld_d[0]   = !flush_ex_i && !stall_o && ex_valid_i && ex_regwrite_i && (ex_rd_i != '0);
      rd_d[0]    = ex_rd_i;
      avail_d[0] = ex_is_load_i ? SelW'(LoadStage) : SelW'(1);
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q       <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < Depth; k++) begin
        rd_q[k]    <= '0;
        avail_q[k] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < Depth; k++) begin
        rd_q[k]    <= rd_d[k];
        avail_q[k] <= avail_d[k];
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomized bench for forwarding_scoreboard against a queue-based model of in-flight producers.
module tb_forwarding_scoreboard;

  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned NumSrc    = 2;
  localparam int unsigned Depth     = 3;
  localparam int unsigned LoadStage = 3;
  localparam int unsigned CntW      = 4;
  localparam int unsigned SelW      = $clog2(Depth + 1);
  localparam int unsigned NumCycles = 800;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic                       ex_valid_i;
  logic [RegAddrW-1:0]        ex_rd_i;
  logic                       ex_regwrite_i;
  logic                       ex_is_load_i;
  logic [NumSrc*RegAddrW-1:0] ex_rs_i;
  logic [NumSrc-1:0]          ex_rs_used_i;
  logic                       hold_i;
  logic                       flush_ex_i;
  logic [NumSrc*SelW-1:0]     sel_o;
  logic                       stall_o;
  logic [CntW-1:0]            stall_cnt_o;

  forwarding_scoreboard #(
    .RegAddrW (RegAddrW),
    .NumSrc   (NumSrc),
    .Depth    (Depth),
    .LoadStage(LoadStage),
    .CntW     (CntW)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_rd_i      (ex_rd_i),
    .ex_regwrite_i(ex_regwrite_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_rs_i      (ex_rs_i),
    .ex_rs_used_i (ex_rs_used_i),
    .hold_i       (hold_i),
    .flush_ex_i   (flush_ex_i),
    .sel_o        (sel_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit v;
    int rd;
    int av;
  } prod_t;

  // Element 0 is the youngest producer (stage 1).
  prod_t sb[$];
  int    exp_cnt;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    prod_t b;
    b.v = 0; b.rd = 0; b.av = 0;
    sb.delete();
    for (int k = 0; k < Depth; k++) sb.push_back(b);
    exp_cnt = 0;
  endtask

  task automatic randomize_inputs(input bit keep);
    hold_i     = ($urandom_range(0, 9) == 0);
    flush_ex_i = ($urandom_range(0, 11) == 0);
    if (!keep) begin
      ex_valid_i    = ($urandom_range(0, 9) != 0);
      ex_rd_i       = RegAddrW'($urandom_range(0, 3));
      ex_regwrite_i = ($urandom_range(0, 4) != 0);
      ex_is_load_i  = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NumSrc; i++) begin
        ex_rs_i[i*RegAddrW +: RegAddrW] = RegAddrW'($urandom_range(0, 3));
        ex_rs_used_i[i]                 = ($urandom_range(0, 6) != 0);
      end
    end
  endtask

  initial begin
    int  exp_sel [NumSrc];
    bit  exp_stall;
    bit  prev_stall;
    prod_t np;

    rst_i = 1'b1;
    randomize_inputs(1'b0);
    model_reset();
    prev_stall = 0;
    #2;
    check_eq("reset_cnt", int'(stall_cnt_o), 0);
    check_eq("reset_stall", int'(stall_o), 0);
    check_eq("reset_sel", int'(sel_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk_i);
      // A stalled consumer normally re-presents the same instruction.
      randomize_inputs(prev_stall && ($urandom_range(0, 4) != 0));
      #1;
      if (cyc == NumCycles / 2) begin
        rst_i = 1'b1;
        #1;
        check_eq("midrst_sel", int'(sel_o), 0);
        check_eq("midrst_stall", int'(stall_o), 0);
        check_eq("midrst_cnt", int'(stall_cnt_o), 0);
        rst_i = 1'b0;
        model_reset();
        #1;
      end

      exp_stall = 0;
      for (int i = 0; i < NumSrc; i++) begin
        int rs;
        rs         = int'(ex_rs_i[i*RegAddrW +: RegAddrW]);
        exp_sel[i] = 0;
        if (ex_valid_i && ex_rs_used_i[i] && rs != 0) begin
          for (int j = 0; j < Depth; j++) begin
            if (sb[j].v && sb[j].rd == rs) begin
              exp_sel[i] = j + 1;
              if (sb[j].av > j + 1) exp_stall = 1;
              break;
            end
          end
        end
      end
      if (!ex_valid_i || flush_ex_i) exp_stall = 0;

      for (int i = 0; i < NumSrc; i++) begin
        check_eq($sformatf("sel%0d", i), int'(sel_o[i*SelW +: SelW]), exp_sel[i]);
      end
      check_eq("stall", int'(stall_o), int'(exp_stall));
      check_eq("stall_cnt", int'(stall_cnt_o), exp_cnt);

      if (!hold_i) begin
        np.v  = ex_valid_i && ex_regwrite_i && (ex_rd_i != 0) && !flush_ex_i && !exp_stall;
        np.rd = int'(ex_rd_i);
        np.av = ex_is_load_i ? LoadStage : 1;
        sb.push_front(np);
        void'(sb.pop_back());
        if (exp_stall && exp_cnt < (1 << CntW) - 1) exp_cnt++;
      end
      prev_stall = exp_stall && !flush_ex_i;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
